// File: rtl/word_align_pkg.sv
// Shared types and constants for the word-alignment stage: FSM state encoding,
// default lock/miss thresholds and the bit-offset width.
package word_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED,
    ST_MANUAL
  } state_e;

  localparam int DEF_LOCK_COUNT = 8;
  localparam int DEF_MISS_LIMIT = 4;
  localparam int OFFSET_W       = 3;

  // Lowest set index of the match vector; earliest offset wins a tie.
  function automatic logic [OFFSET_W-1:0] lowest_set(input logic [7:0] v);
    logic [OFFSET_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = OFFSET_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/word_align_utility_if.sv
// Parallel word stream into and out of the word-alignment stage.
interface word_align_utility_if;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;

  modport master (output din, output din_valid, input dout, input dout_valid);
  modport slave  (input din, input din_valid, output dout, output dout_valid);
endinterface

// File: rtl/word_shift_utility.sv
// Combinational 16->8 window selector: picks win[offset+7:offset].
module word_shift_utility
  import word_align_pkg::*;
(
  input  logic [15:0]         win,
  input  logic [OFFSET_W-1:0] offset,
  output logic [7:0]          word
);
  assign word = win[offset +: 8];
endmodule

// File: rtl/word_align_utility.sv
// Word-alignment stage: searches all eight offsets of a two-word window for a
// sync pattern, confirms lock, realigns data. Optional macro: WORD_ALIGN_MANUAL_EN.
module word_align_utility
  import word_align_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT,
  parameter int ERR_W      = 16
) (
  input  logic                 clk160,
  input  logic                 rstb,
  word_align_utility_if.slave  bus,
  input  logic                 delay_ready,
  input  logic [7:0]           sync_pattern,
  input  logic                 check_en,
  input  logic                 realign,
  input  logic                 reset_counters,
`ifdef WORD_ALIGN_MANUAL_EN
  input  logic                 manual_mode,
  input  logic [OFFSET_W-1:0]  manual_offset,
`endif
  output logic [OFFSET_W-1:0]  bit_offset,
  output logic                 locked,
  output logic [ERR_W-1:0]     word_err_cnt,
  output logic [7:0]           lock_loss_cnt
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [MS_W-1:0] MISS_LAST  = MS_W'(MISS_LIMIT - 1);

  state_e               state_q, state_d;
  logic [7:0]           prev_q, prev_d;
  logic [OFFSET_W-1:0]  cand_q, cand_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic [MS_W-1:0]      miss_cnt_q, miss_cnt_d;
  logic [OFFSET_W-1:0]  bit_offset_q, bit_offset_d;
  logic [ERR_W-1:0]     word_err_cnt_q, word_err_cnt_d;
  logic [7:0]           lock_loss_cnt_q, lock_loss_cnt_d;
  logic [7:0]           dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;

  logic [15:0] win;
  logic [7:0]  m;
  logic [7:0]  dout_sel;
  logic        err_inc;
  logic        loss_inc;
  logic        in_manual;

  assign win = {bus.din, prev_q};

  for (genvar gi = 0; gi < 8; gi++) begin : g_tap
    logic [7:0] tap;
    word_shift_utility u_tap (
      .win    (win),
      .offset (OFFSET_W'(gi)),
      .word   (tap)
    );
    assign m[gi] = (tap == sync_pattern);
  end

  word_shift_utility u_dout (
    .win    (win),
    .offset (bit_offset_q),
    .word   (dout_sel)
  );

`ifdef WORD_ALIGN_MANUAL_EN
  assign in_manual = (state_q == ST_MANUAL);
`else
  assign in_manual = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    bit_offset_d = bit_offset_q;
    err_inc      = 1'b0;
    loss_inc     = 1'b0;

    if (!delay_ready) begin
      state_d = ST_IDLE;
    end else if (realign && !(state_q inside {ST_IDLE, ST_SETTLE})) begin
      state_d = ST_SEARCH;
`ifdef WORD_ALIGN_MANUAL_EN
    end else if (manual_mode && !(state_q inside {ST_IDLE, ST_MANUAL})) begin
      state_d      = ST_MANUAL;
      bit_offset_d = manual_offset;
`endif
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SETTLE;
        ST_SETTLE: if (bus.din_valid) state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (bus.din_valid && (m != 8'h00)) begin
            cand_d  = lowest_set(m);
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (bus.din_valid) begin
            if (!m[cand_q]) begin
              state_d = ST_SEARCH;
            end else if (match_cnt_q == MATCH_LAST) begin
              state_d      = ST_LOCKED;
              bit_offset_d = cand_q;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bus.din_valid && check_en) begin
            if (m[bit_offset_q]) begin
              miss_cnt_d = '0;
            end else begin
              err_inc = 1'b1;
              if (miss_cnt_q == MISS_LAST) begin
                loss_inc = 1'b1;
                state_d  = ST_SEARCH;
              end else begin
                miss_cnt_d = miss_cnt_q + 1'b1;
              end
            end
          end
        end
`ifdef WORD_ALIGN_MANUAL_EN
        ST_MANUAL: begin
          bit_offset_d = manual_offset;
          if (bus.din_valid && check_en && !m[manual_offset]) err_inc = 1'b1;
          if (!manual_mode) state_d = ST_SEARCH;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    // Entering any state restarts both run-length counters; the first hit
    // in SEARCH already counts as one match.
    if (state_d != state_q) begin
      miss_cnt_d  = '0;
      match_cnt_d = (state_d == ST_CONFIRM) ? MC_W'(1) : '0;
    end
  end

  always_comb begin
    word_err_cnt_d  = word_err_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    if (reset_counters) begin
      word_err_cnt_d  = '0;
      lock_loss_cnt_d = '0;
    end else begin
      if (err_inc && !(&word_err_cnt_q))   word_err_cnt_d  = word_err_cnt_q + 1'b1;
      if (loss_inc && !(&lock_loss_cnt_q)) lock_loss_cnt_d = lock_loss_cnt_q + 1'b1;
    end
  end

  always_comb begin
    prev_d       = bus.din_valid ? bus.din : prev_q;
    dout_d       = dout_sel;
    dout_valid_d = bus.din_valid & (locked | in_manual);
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q         <= ST_IDLE;
      prev_q          <= '0;
      cand_q          <= '0;
      match_cnt_q     <= '0;
      miss_cnt_q      <= '0;
      bit_offset_q    <= '0;
      word_err_cnt_q  <= '0;
      lock_loss_cnt_q <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      cand_q          <= cand_d;
      match_cnt_q     <= match_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      bit_offset_q    <= bit_offset_d;
      word_err_cnt_q  <= word_err_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
    end
  end

  assign locked         = (state_q == ST_LOCKED);
  assign bit_offset     = bit_offset_q;
  assign word_err_cnt   = word_err_cnt_q;
  assign lock_loss_cnt  = lock_loss_cnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
